// File: rtl/nes_pkg.sv
// Shared NES bus definitions: OAM DMA state encoding and fixed register addresses.
package nes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } oam_dma_state_t;

    localparam logic [15:0] OAMDMA_REG  = 16'h4014;
    localparam logic [15:0] OAMDATA_REG = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: copies a 256-byte CPU page into the PPU OAM data port.
// Latency: 1 halt cycle, optional 1 align cycle, then 256 read/write pairs.
// Backpressure: stalls the CPU through cpu_ready for the whole transfer.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = nes_pkg::OAMDMA_REG,
    parameter logic [15:0] OAM_DATA_ADDR = nes_pkg::OAMDATA_REG
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_d_out,
    input  logic [7:0]  bus_d_in,
    output logic        cpu_ready,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_write,
    output logic [7:0]  dma_d_out
);
    import nes_pkg::*;

    oam_dma_state_t state, state_nxt;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data;
    logic       parity;
    logic       trigger;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            page   <= 8'h00;
            idx    <= 8'h00;
            data   <= 8'h00;
            parity <= 1'b0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            if (trigger) begin
                page <= cpu_d_out;
                idx  <= 8'h00;
            end
            if (state == ST_READ) begin
                data <= bus_d_in;
            end
            if (state == ST_WRITE) begin
                idx <= idx + 8'h01;
            end
        end
    end

    // Outputs depend only on registered state; cpu inputs only steer the next state.
    always_comb begin
        state_nxt  = state;
        trigger    = 1'b0;
        cpu_ready  = 1'b0;
        dma_active = 1'b0;
        dma_addr   = 16'h0000;
        dma_write  = 1'b0;
        dma_d_out  = data;
        case (state)
            ST_IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_write && (cpu_addr == DMA_REG_ADDR)) begin
                    trigger   = 1'b1;
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                state_nxt = parity ? ST_READ : ST_ALIGN;
            end
            ST_ALIGN: begin
                state_nxt = ST_READ;
            end
            ST_READ: begin
                dma_active = 1'b1;
                dma_addr   = {page, idx};
                state_nxt  = ST_WRITE;
            end
            ST_WRITE: begin
                dma_active = 1'b1;
                dma_addr   = OAM_DATA_ADDR;
                dma_write  = 1'b1;
                state_nxt  = (idx == 8'hFF) ? ST_IDLE : ST_READ;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: model memory on the bus, scoreboard of read bytes versus OAM writes.
module tb_oam_dma;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_write;
    logic [7:0]  cpu_d_out;
    logic [7:0]  bus_d_in;
    logic        cpu_ready;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_write;
    logic [7:0]  dma_d_out;

    int checks = 0;
    int errors = 0;
    logic tb_par;
    logic [7:0] exp_q[$];

    oam_dma dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_write  (cpu_write),
        .cpu_d_out  (cpu_d_out),
        .bus_d_in   (bus_d_in),
        .cpu_ready  (cpu_ready),
        .dma_active (dma_active),
        .dma_addr   (dma_addr),
        .dma_write  (dma_write),
        .dma_d_out  (dma_d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running parity reference: 0 in the first cycle after reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_par <= 1'b0;
        else       tb_par <= ~tb_par;
    end

    // Page 03 holds offset values; other pages are scrambled by the page number.
    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        return (a[15:8] == 8'h03) ? a[7:0] : (a[7:0] ^ a[15:8]);
    endfunction

    assign bus_d_in = mem_rd(dma_addr);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cpu();
        cpu_write = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_d_out = 8'h00;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_write = 1'b1;
        cpu_addr  = a;
        cpu_d_out = d;
    endtask

    // mode 0: plain; 1: ignored write at idx 40; 2: ignored write on the final WRITE cycle
    task automatic run_transfer(input logic [7:0] pg, input logic want_par, input int mode);
        int stall, rd, wr, exp_stall;
        logic [7:0] idx_e;
        logic prev_rd;
        logic [15:0] first_a, last_a;
        logic [7:0] exp_b;
        stall = 0; rd = 0; wr = 0; idx_e = 8'h00; prev_rd = 1'b0;
        first_a = 16'h0000; last_a = 16'h0000;
        if (tb_par == want_par) tick();
        cpu_wr(16'h4014, pg);
        tick();
        clear_cpu();
        chk("halt_ready", 32'(cpu_ready), 32'd0);
        chk("halt_active", 32'(dma_active), 32'd0);
        exp_stall = tb_par ? 513 : 514;
        for (int c = 0; c < 600 && cpu_ready == 1'b0; c++) begin
            clear_cpu();
            stall++;
            if (dma_active && !dma_write) begin
                chk("rd_addr", 32'(dma_addr), 32'({pg, idx_e}));
                if (rd == 0) first_a = dma_addr;
                last_a = dma_addr;
                exp_q.push_back(mem_rd(dma_addr));
                rd++;
                prev_rd = 1'b1;
                if (mode == 1 && idx_e == 8'h40) cpu_wr(16'h4014, 8'h07);
            end else if (dma_active && dma_write) begin
                chk("wr_addr", 32'(dma_addr), 32'h2004);
                chk("wr_after_rd", 32'(prev_rd), 32'd1);
                exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                chk("wr_data", 32'(dma_d_out), 32'(exp_b));
                if (mode == 2 && idx_e == 8'hFF) cpu_wr(16'h4014, 8'h09);
                wr++;
                idx_e++;
                prev_rd = 1'b0;
            end else begin
                chk("pre_rd_idle_bus", 32'({dma_write, dma_addr}), 32'd0);
                chk("stall_before_rd", 32'(rd), 32'd0);
            end
            tick();
        end
        clear_cpu();
        chk("stall_cycles", 32'(stall), 32'(exp_stall));
        chk("read_count", 32'(rd), 32'd256);
        chk("write_count", 32'(wr), 32'd256);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("first_rd_addr", 32'(first_a), 32'({pg, 8'h00}));
        chk("last_rd_addr", 32'(last_a), 32'({pg, 8'hFF}));
        chk("held_data", 32'(dma_d_out), 32'(mem_rd({pg, 8'hFF})));
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_ready", 32'(cpu_ready), 32'd1);
            chk("post_active", 32'(dma_active), 32'd0);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  d;
        logic        exp_ready;
        logic        exp_active;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        reset = 1'b1;
        clear_cpu();
        tbl[0] = '{16'h4015, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[1] = '{16'h2004, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[2] = '{16'h4014, 1'b0, 8'h02, 1'b1, 1'b0};
        tbl[3] = '{16'h0000, 1'b1, 8'h02, 1'b1, 1'b0};
        tbl[4] = '{16'h4013, 1'b1, 8'hFF, 1'b1, 1'b0};

        tick();
        tick();
        chk("rst_ready", 32'(cpu_ready), 32'd1);
        chk("rst_active", 32'(dma_active), 32'd0);
        chk("rst_write", 32'(dma_write), 32'd0);
        chk("rst_addr", 32'(dma_addr), 32'd0);
        chk("rst_dout", 32'(dma_d_out), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            cpu_addr  = tbl[i].addr;
            cpu_write = tbl[i].wr;
            cpu_d_out = tbl[i].d;
            tick();
            clear_cpu();
            chk("vec_ready", 32'(cpu_ready), 32'(tbl[i].exp_ready));
            chk("vec_active", 32'(dma_active), 32'(tbl[i].exp_active));
            tick();
            chk("vec_ready_hold", 32'(cpu_ready), 32'(tbl[i].exp_ready));
        end

        run_transfer(8'h02, 1'b1, 0);
        run_transfer(8'h03, 1'b0, 1);
        run_transfer(8'hFF, 1'b1, 2);

        // Reset lands in the WRITE of idx 80.
        cpu_wr(16'h4014, 8'h05);
        tick();
        clear_cpu();
        n = 0;
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            if (dma_active && dma_write) begin
                if (n == 8'h80) found = 1'b1;
                else n++;
            end
            if (!found) tick();
        end
        chk("rst_mid_found", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_mid_write", 32'(dma_write), 32'd0);
        chk("rst_mid_ready", 32'(cpu_ready), 32'd1);
        chk("rst_mid_active", 32'(dma_active), 32'd0);
        chk("rst_mid_dout", 32'(dma_d_out), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_rel_ready", 32'(cpu_ready), 32'd1);
        chk("rst_rel_addr", 32'(dma_addr), 32'd0);
        run_transfer(8'h05, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
